// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM encoding and counter width helper for the debounce bank
package debounce_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, HELD = 2'd2} state_t;
   function automatic int cnt_w(input int v);
      return (v < 1) ? 1 : $clog2(v + 1);
   endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, stability filter and hold/repeat FSM for one button
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = 4,
   parameter int HOLD_TICKS   = 400,
   parameter int REPEAT_TICKS = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn,
   output logic level,
   output logic press,
   output logic rel,
   output logic hold
);
   localparam int SW = cnt_w(STABLE_TICKS);
   localparam int HW = cnt_w(HOLD_TICKS > REPEAT_TICKS ? HOLD_TICKS : REPEAT_TICKS);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS == 0 ? 0 : REPEAT_TICKS - 1);
   logic meta, sync, differ, flip, rise, fall, hold_fire;
   logic [SW-1:0] stab_cnt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   state_t state, state_nxt;
   assign differ = sync != level;
   assign flip   = tick && differ && stab_cnt == STAB_LAST;
   assign rise   = flip && !level;
   assign fall   = flip && level;
   always_ff @(posedge clk) begin
      if (rst) begin
         meta     <= 1'b0;
         sync     <= 1'b0;
         stab_cnt <= '0;
         level    <= 1'b0;
         press    <= 1'b0;
         rel      <= 1'b0;
         hold     <= 1'b0;
      end else begin
         meta  <= btn;
         sync  <= meta;
         press <= rise;
         rel   <= fall;
         hold  <= hold_fire;
         if (tick) begin
            stab_cnt <= (differ && !flip) ? stab_cnt + 1'b1 : '0;
            level    <= level ^ flip;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      if (fall) begin
         state_nxt = IDLE;
         hold_nxt  = '0;
      end else if (rise) begin
         state_nxt = PRESSED;
         hold_nxt  = '0;
      end else if (tick) begin
         if (state == PRESSED) begin
            state_nxt = (hold_cnt == HOLD_LAST) ? HELD : PRESSED;
            hold_nxt  = (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
         end else if (state == HELD && REPEAT_TICKS != 0) begin
            hold_nxt = (hold_cnt == REP_LAST) ? '0 : hold_cnt + 1'b1;
         end
      end
   end
   // a release tick never carries a hold pulse, even if the count lands on it
   always_comb begin
      hold_fire = tick && !fall &&
                  (state == PRESSED ? hold_cnt == HOLD_LAST
                                    : state == HELD && REPEAT_TICKS != 0 && hold_cnt == REP_LAST);
   end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: shared sample-tick generator driving N_CH independent button conditioners
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int N_CH         = 5,
   parameter int TICK_DIV     = 250000,
   parameter int STABLE_TICKS = 4,
   parameter int HOLD_TICKS   = 400,
   parameter int REPEAT_TICKS = 40
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] hold_pulse
);
   localparam int TW = cnt_w(TICK_DIV - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   logic [TW-1:0] tick_cnt;
   logic tick;
   assign tick = tick_cnt == TICK_LAST;
   always_ff @(posedge clk) begin
      if (rst) tick_cnt <= '0;
      else     tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS(STABLE_TICKS),
         .HOLD_TICKS  (HOLD_TICKS),
         .REPEAT_TICKS(REPEAT_TICKS)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .tick (tick),
         .btn  (btn_in[c]),
         .level(btn_level[c]),
         .press(press_pulse[c]),
         .rel  (release_pulse[c]),
         .hold (hold_pulse[c])
      );
   end
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button conditioner, successor to the single-button debouncer. It synchronises N raw button inputs and debounces each with an N-sample stability filter, driven by one shared slow-tick enable. Per channel it emits a clean level, one-cycle press and release pulses, and a long-press / auto-repeat pulse. It sits between the board pushbuttons and the ATM menu/keypad FSMs, all in the single `clk` domain.

## Interface
- `N_CH`, 5, number of independent button channels
- `TICK_DIV`, 250000, `clk` cycles per sample tick (2.5 ms at 100 MHz); legal ≥ 2
- `STABLE_TICKS`, 4, consecutive disagreeing samples required to flip the level; legal ≥ 1
- `HOLD_TICKS`, 400, ticks of continuous press before the first hold pulse (1 s); legal ≥ 1
- `REPEAT_TICKS`, 40, ticks between subsequent hold pulses (100 ms); 0 = auto-repeat disabled (single hold pulse only)
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `btn_in`  in  N_CH  raw asynchronous button inputs, 1 = pressed
- `btn_level`  out  N_CH  debounced level per channel
- `press_pulse`  out  N_CH  one-`clk` pulse on debounced 0→1
- `release_pulse`  out  N_CH  one-`clk` pulse on debounced 1→0
- `hold_pulse`  out  N_CH  one-`clk` pulse on long press and each auto-repeat

## Operation
- Synchroniser: 2-flop chain per channel, clocked every `clk`, no enable; `sync` = second flop.
- Tick generator: counter 0..TICK_DIV-1 that wraps. `tick` is high for exactly one `clk` when counter == TICK_DIV-1. It is shared by all channels.
- Per channel, on `tick` only:
  - If `sync` ≠ `btn_level`: `stab_cnt`++. When the increment would reach STABLE_TICKS, toggle `btn_level`, clear `stab_cnt`, and fire the press or release pulse.
  - If `sync` == `btn_level`: clear `stab_cnt`. A single glitch sample restarts the filter.
- Per-channel FSM with states IDLE, PRESSED, HELD:
  - IDLE → PRESSED on the level rise. `hold_cnt` cleared.
  - PRESSED: `hold_cnt`++ per tick. On reaching HOLD_TICKS, fire `hold_pulse`, clear `hold_cnt`, go to HELD.
  - HELD: if REPEAT_TICKS ≠ 0, `hold_cnt`++ per tick and fire `hold_pulse` each time it reaches REPEAT_TICKS, then clear it. If REPEAT_TICKS = 0, no further pulses.
  - Any state → IDLE on the level fall. `hold_cnt` cleared. No hold pulse in the release cycle.
- Channels are fully independent. Simultaneous events on different channels all fire in the same cycle.
- Counter widths: `$clog2(param+1)`. Counters saturate logically via the clear-on-reach rule and never wrap.

## Timing
- Reset (synchronous): all outputs 0. Sync flops, tick counter, `stab_cnt` and `hold_cnt` all 0. FSM = IDLE. Reset overrides `tick` in the same cycle.
- Reset mid-press: after reset `btn_level` = 0. A still-held button is re-detected after STABLE_TICKS ticks and produces a fresh `press_pulse`. No `release_pulse` is generated by reset.
- Output registers update on the `clk` edge where `tick` is sampled high. `btn_level` and `press_pulse`/`release_pulse` change in the same cycle. All pulses are exactly one `clk` wide.
- Press latency from a clean input edge: 2 `clk` (sync), plus the wait until the next tick, plus (STABLE_TICKS-1)·TICK_DIV. Bounds: min 2+1+(S-1)·D, max 2+D+(S-1)·D cycles, with S = STABLE_TICKS and D = TICK_DIV.
- First `hold_pulse` fires HOLD_TICKS ticks after `press_pulse`. Repeats follow every REPEAT_TICKS ticks.
- Bounce shorter than STABLE_TICKS consecutive samples produces no output change.

## Structure
- Shared package `debounce_pkg`: FSM state encoding (IDLE = 0, PRESSED = 1, HELD = 2) and a width helper constant function.
- Sub-module `debounce_channel`: synchroniser, stability filter, and hold/repeat FSM for one channel.
- Top `debounce_bank`: tick generator plus a generate loop of N_CH `debounce_channel` instances.

## Test plan
Bench parameters unless noted: N_CH = 2, TICK_DIV = 4, STABLE_TICKS = 3, HOLD_TICKS = 5, REPEAT_TICKS = 2.
- Clean press on ch0, held 100 cycles → `btn_level[0]` rises with one `press_pulse[0]` within 11–14 cycles of the edge. ch1 stays quiet.
- Bounce: ch0 toggles on alternate ticks for 10 ticks, then stays high → no pulses during the bounce. `press_pulse` fires exactly 3 ticks after the last toggle.
- Long hold: ch0 held 20 ticks → `hold_pulse` 5 ticks after the press, then at +7, +9, +11 … ticks. Release → one `release_pulse` and no further hold pulses.
- REPEAT_TICKS = 0, ch0 held 20 ticks → exactly one `hold_pulse`.
- Both channels pressed on the same cycle → `press_pulse` = 2'b11 in a single cycle.
- Assert `rst` for 1 cycle while ch0 is held in HELD → all outputs 0 the next cycle. A fresh `press_pulse[0]` follows 3 ticks later, with no `release_pulse`.
